// File: rtl/reg_file_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port between the ALU (A) and the LSU (B).
// Define WB_ZERO_INIT_EN to add a post-reset sweep that zero-writes registers 1..NREGS-1.
module reg_file_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_busy,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              last_grant_q, last_grant_d;
  logic              run;

`ifdef WB_ZERO_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
`endif

  always_comb begin
    // On a tie the requester that did not win last time is served.
    a_ready      = run & a_valid & (~b_valid | (last_grant_q == GRANT_B));
    b_ready      = run & b_valid & (~a_valid | (last_grant_q == GRANT_A));
    wr_en_d      = 1'b0;
    wr_d         = wr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
`ifdef WB_ZERO_INIT_EN
    state_d      = state_q;
    idx_d        = idx_q;
`endif
    if (a_ready) begin
      wr_en_d      = (a_rd != '0);
      wr_d         = a_rd;
      wr_data_d    = a_data;
      last_grant_d = GRANT_A;
    end else if (b_ready) begin
      wr_en_d      = (b_rd != '0);
      wr_d         = b_rd;
      wr_data_d    = b_data;
      last_grant_d = GRANT_B;
    end
`ifdef WB_ZERO_INIT_EN
    if (state_q == ST_INIT) begin
      wr_en_d   = 1'b1;
      wr_d      = idx_q;
      wr_data_d = '0;
      idx_d     = idx_q + 1'b1;
      if (idx_q == ADDR_W'(NREGS - 1)) state_d = ST_RUN;
    end
`endif
    wr_count_d = wr_count_q;
    if (wr_en_d && (wr_count_q != {CNT_W{1'b1}})) wr_count_d = wr_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_q         <= '0;
      wr_data_q    <= '0;
      wr_count_q   <= '0;
      last_grant_q <= GRANT_B;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_q         <= wr_d;
      wr_data_q    <= wr_data_d;
      wr_count_q   <= wr_count_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef WB_ZERO_INIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
`endif

  assign wr_en    = wr_en_q;
  assign wr       = wr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed bench for reg_file_wb_arbiter: handshake, round-robin order, x0 filter, reset and counter saturation.
// Works with or without WB_ZERO_INIT_EN defined.
module tb_reg_file_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_rd, b_rd;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] wr_data;
  logic              init_busy;
  logic [CNT_W-1:0]  wr_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt;

  reg_file_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr(wr), .wr_data(wr_data),
    .init_busy(init_busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
    step(); step();

    // Reset values
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr", wr, 0);
    check_val("rst_wr_data", wr_data, 0);
    check_val("rst_count", wr_count, 0);
`ifdef WB_ZERO_INIT_EN
    check_val("rst_init_busy", init_busy, 1);
`else
    check_val("rst_init_busy", init_busy, 0);
`endif

`ifdef WB_ZERO_INIT_EN
    // Init sweep: A holds an x0 request that must not be served until the last sweep cycle.
    a_valid = 1'b1; a_rd = '0;
    rst = 1'b0;
    for (int k = 1; k < NREGS; k++) begin
      step();
      check_val($sformatf("init_wr_en_%0d", k), wr_en, 1);
      check_val($sformatf("init_wr_%0d", k), wr, k);
      check_val($sformatf("init_data_%0d", k), wr_data, 0);
      check_val($sformatf("init_busy_%0d", k), init_busy, (k < NREGS - 1) ? 1 : 0);
      check_val($sformatf("init_a_ready_%0d", k), a_ready, (k < NREGS - 1) ? 0 : 1);
    end
    check_val("init_count", wr_count, NREGS - 1);
    a_valid = 1'b0;
    exp_cnt = NREGS - 1;
`else
    rst = 1'b0;
    exp_cnt = 0;
`endif

    // Single A write
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check_val("t2_a_ready", a_ready, 1);
    check_val("t2_b_ready", b_ready, 0);
    step();
    a_valid = 1'b0;
    exp_cnt++;
    check_val("t2_wr_en", wr_en, 1);
    check_val("t2_wr", wr, 5);
    check_val("t2_wr_data", wr_data, 64'hDEADBEEF);
    check_val("t2_count", wr_count, exp_cnt);
    step();
    check_val("t2_wr_en_off", wr_en, 0);
    check_val("t2_wr_hold", wr, 5);
    check_val("t2_data_hold", wr_data, 64'hDEADBEEF);

    // B write to x0 is accepted but filtered
    b_valid = 1'b1; b_rd = '0; b_data = 32'h1234;
    #1;
    check_val("t4_b_ready", b_ready, 1);
    check_val("t4_a_ready", a_ready, 0);
    step();
    b_valid = 1'b0;
    check_val("t4_wr_en", wr_en, 0);
    check_val("t4_count", wr_count, exp_cnt);

    // Contention: last grant was B, so A, B, A, B
    a_valid = 1'b1; b_valid = 1'b1;
    a_rd = 5'd3; b_rd = 5'd4;
    a_data = 32'hA000_0000; b_data = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      logic             a_turn;
      logic [ADDR_W-1:0] exp_rd;
      logic [DATA_W-1:0] exp_d;
      a_turn = (i % 2 == 0);
      exp_rd = a_turn ? 5'd3 : 5'd4;
      exp_d  = a_turn ? a_data : b_data;
      #1;
      check_val($sformatf("t3_a_ready_%0d", i), a_ready, a_turn);
      check_val($sformatf("t3_b_ready_%0d", i), b_ready, !a_turn);
      step();
      exp_cnt++;
      check_val($sformatf("t3_wr_en_%0d", i), wr_en, 1);
      check_val($sformatf("t3_wr_%0d", i), wr, exp_rd);
      check_val($sformatf("t3_data_%0d", i), wr_data, exp_d);
      check_val($sformatf("t3_count_%0d", i), wr_count, exp_cnt);
      if (a_turn) a_data = a_data + 1; else b_data = b_data + 1;
      if (i == 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
    end
    step();
    check_val("t3_wr_en_off", wr_en, 0);

    // Reset while a write is being presented
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h55;
    step();
    a_valid = 1'b0;
    check_val("t5_wr_en_pre", wr_en, 1);
    #1 rst = 1'b1;
    #1;
    check_val("t5_wr_en_async", wr_en, 0);
    check_val("t5_wr_async", wr, 0);
    check_val("t5_data_async", wr_data, 0);
    check_val("t5_count_async", wr_count, 0);
    step();
    rst = 1'b0;
`ifdef WB_ZERO_INIT_EN
    step();
    check_val("t5_restart_wr_en", wr_en, 1);
    check_val("t5_restart_wr", wr, 1);
    check_val("t5_restart_busy", init_busy, 1);
    for (int g = 0; g < 2 * NREGS && init_busy; g++) step();
    check_val("t5_init_done", init_busy, 0);
    exp_cnt = NREGS - 1;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0;
    #1;
`else
    exp_cnt = 0;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0;
    #1;
`endif
    check_val("t5_a_ready", a_ready, 1);

    // Saturation: 2^CNT_W+3 accepted writes to rd=7
    begin
      int base;
      base = exp_cnt;
      for (int k = 1; k <= (1 << CNT_W) + 3; k++) begin
        step();
        exp_cnt = (base + k > CNT_MAX) ? CNT_MAX : base + k;
        if (k == 1) begin
          check_val("t6_wr_en", wr_en, 1);
          check_val("t6_wr", wr, 7);
        end
        if (k == CNT_MAX - 1 - base || k == CNT_MAX - base || k == (1 << CNT_W) + 3)
          check_val($sformatf("t6_count_k%0d", k), wr_count, exp_cnt);
      end
    end
    a_valid = 1'b0;
    step();
    check_val("t6_count_final", wr_count, CNT_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
